// File: rtl/serving_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serving_timer_pkg: shared register map, CTRL field layout and helpers      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package serving_timer_pkg;

    // Word addresses (adr[3:2]) of the 16-byte block: 0x0, 0x4, 0x8, 0xC
    typedef enum logic [1:0] {
        REG_MTIME    = 2'd0,
        REG_MTIMECMP = 2'd1,
        REG_CTRL     = 2'd2,
        REG_STATUS   = 2'd3
    } reg_adr_e;

    localparam int c_presc_w        = 8;
    localparam int c_ctrl_en        = 0;
    localparam int c_ctrl_irq_en    = 1;
    localparam int c_ctrl_presc_lsb = 8;
    localparam int c_status_pending = 0;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serving_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serving_timer_if: Wishbone-style register bus between CPU and timer        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface serving_timer_if;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/serving_timer_presc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serving_timer_presc: divide-by-(presc+1) counter producing a 1-cycle tick  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serving_timer_presc
    import serving_timer_pkg::*;
#(
    parameter int WIDTH = c_presc_w
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic [WIDTH-1:0] i_presc,
    output logic                  o_tick
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == i_presc);
    assign o_tick = i_en & ~i_clr & w_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serving_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serving_timer: memory-mapped MTIME/MTIMECMP timer with level interrupt     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serving_timer
    import serving_timer_pkg::*;
#(
    parameter logic [7:0]  PRESC_RESET = 8'd0,
    parameter logic [31:0] CMP_RESET   = 32'hFFFF_FFFF
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    serving_timer_if.slave  wb,
    output logic            o_timer_irq
);

    logic                 r_ack;
    logic [31:0]          r_rdt;
    logic [31:0]          r_mtime;
    logic [31:0]          r_mtimecmp;
    logic                 r_en;
    logic                 r_irq_en;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_pending;

    reg_adr_e             w_adr;
    logic                 w_acc;
    logic                 w_wr;
    logic                 w_wr_mtime;
    logic                 w_wr_cmp;
    logic                 w_wr_ctrl;
    logic                 w_wr_status;
    logic                 w_presc_clr;
    logic                 w_status_clr;
    logic                 w_match;
    logic                 w_tick;
    logic [31:0]          w_rd_data;

    // A request is accepted only when no ack is outstanding, so a held strobe
    // alternates ack and never produces two back-to-back acks.
    assign w_adr        = reg_adr_e'(wb.i_wb_adr);
    assign w_acc        = wb.i_wb_stb & ~r_ack;
    assign w_wr         = w_acc & wb.i_wb_we;
    assign w_wr_mtime   = w_wr && (w_adr == REG_MTIME);
    assign w_wr_cmp     = w_wr && (w_adr == REG_MTIMECMP);
    assign w_wr_ctrl    = w_wr && (w_adr == REG_CTRL);
    assign w_wr_status  = w_wr && (w_adr == REG_STATUS);
    assign w_presc_clr  = w_wr_ctrl & wb.i_wb_sel[1];
    assign w_status_clr = w_wr_status & wb.i_wb_sel[0] & wb.i_wb_dat[c_status_pending];
    assign w_match      = r_en && (r_mtime == r_mtimecmp);

    serving_timer_presc #(
        .WIDTH (c_presc_w)
    ) u_presc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (r_en),
        .i_clr   (w_presc_clr),
        .i_presc (r_presc),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_rd_data = '0;
        case (w_adr)
            REG_MTIME:    w_rd_data = r_mtime;
            REG_MTIMECMP: w_rd_data = r_mtimecmp;
            REG_CTRL: begin
                w_rd_data[c_ctrl_en]                        = r_en;
                w_rd_data[c_ctrl_irq_en]                    = r_irq_en;
                w_rd_data[c_ctrl_presc_lsb +: c_presc_w]    = r_presc;
            end
            REG_STATUS:   w_rd_data[c_status_pending] = r_pending;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack      <= 1'b0;
            r_rdt      <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= CMP_RESET;
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_presc    <= PRESC_RESET;
            r_pending  <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_rdt <= w_acc ? w_rd_data : 32'd0;

            // A bus write to MTIME overrides a coincident tick
            if (w_wr_mtime) begin
                r_mtime <= f_merge(r_mtime, wb.i_wb_dat, wb.i_wb_sel);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 32'd1;
            end

            if (w_wr_cmp) begin
                r_mtimecmp <= f_merge(r_mtimecmp, wb.i_wb_dat, wb.i_wb_sel);
            end

            if (w_wr_ctrl) begin
                if (wb.i_wb_sel[0]) begin
                    r_en     <= wb.i_wb_dat[c_ctrl_en];
                    r_irq_en <= wb.i_wb_dat[c_ctrl_irq_en];
                end
                if (wb.i_wb_sel[1]) begin
                    r_presc <= wb.i_wb_dat[c_ctrl_presc_lsb +: c_presc_w];
                end
            end

            // Set beats a simultaneous write-one-to-clear
            r_pending <= w_match | (r_pending & ~w_status_clr);
        end
    end

    assign wb.o_wb_ack = r_ack;
    assign wb.o_wb_rdt = r_rdt;
    assign o_timer_irq = r_pending & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_serving_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serving_timer: directed vector table plus multi-cycle corner sequences  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serving_timer;
    import serving_timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serving_timer_if wb_if ();

    serving_timer #(
        .PRESC_RESET (8'd0),
        .CMP_RESET   (32'hFFFF_FFFF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .wb          (wb_if),
        .o_timer_irq (irq)
    );

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output logic [31:0] rd, output int lat);
        logic done;
        @(posedge clk); #1;
        wb_if.i_wb_stb = 1'b1;
        wb_if.i_wb_we  = we;
        wb_if.i_wb_adr = adr;
        wb_if.i_wb_sel = sel;
        wb_if.i_wb_dat = dat;
        lat  = 0;
        rd   = '0;
        done = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!done) begin
                @(posedge clk); #1;
                if (wb_if.o_wb_ack) begin
                    lat  = i;
                    rd   = wb_if.o_wb_rdt;
                    done = 1'b1;
                end
            end
        end
        wb_if.i_wb_stb = 1'b0;
        wb_if.i_wb_we  = 1'b0;
        if (!done) check("ack_timeout", {31'd0, wb_if.o_wb_ack}, 32'd1);
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        int lat;
        wb_access(1'b1, adr, sel, dat, rd, lat);
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] rd);
        int lat;
        wb_access(1'b0, adr, 4'hF, 32'd0, rd, lat);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;

        // Static register behaviour with the timer disabled
        vecs[0]  = '{1'b0, REG_MTIMECMP, 4'hF, 32'h0,         32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, REG_MTIME,    4'hF, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, REG_CTRL,     4'hF, 32'h0,         32'h0000_0000};
        vecs[3]  = '{1'b0, REG_STATUS,   4'hF, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b1, REG_MTIME,    4'b0010, 32'h0000_AB00, 32'h0};
        vecs[5]  = '{1'b0, REG_MTIME,    4'hF, 32'h0,         32'h0000_AB00};
        vecs[6]  = '{1'b1, REG_MTIMECMP, 4'hF, 32'h1234_5678, 32'h0};
        vecs[7]  = '{1'b1, REG_MTIMECMP, 4'b1000, 32'hAA00_0000, 32'h0};
        vecs[8]  = '{1'b0, REG_MTIMECMP, 4'hF, 32'h0,         32'hAA34_5678};
        vecs[9]  = '{1'b1, REG_CTRL,     4'hF, 32'hFFFF_FF02, 32'h0};
        vecs[10] = '{1'b0, REG_CTRL,     4'hF, 32'h0,         32'h0000_FF02};
        vecs[11] = '{1'b1, REG_CTRL,     4'b0010, 32'h0000_0500, 32'h0};
        vecs[12] = '{1'b0, REG_CTRL,     4'hF, 32'h0,         32'h0000_0502};
        vecs[13] = '{1'b1, REG_STATUS,   4'hF, 32'h0000_0001, 32'h0};
        vecs[14] = '{1'b1, REG_MTIME,    4'b0001, 32'h0000_00CD, 32'h0};
        vecs[15] = '{1'b0, REG_MTIME,    4'hF, 32'h0,         32'h0000_ABCD};

        rst = 1'b1;
        wb_if.i_wb_stb = 1'b0;
        wb_if.i_wb_we  = 1'b0;
        wb_if.i_wb_adr = 2'd0;
        wb_if.i_wb_sel = 4'h0;
        wb_if.i_wb_dat = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_ack", {31'd0, wb_if.o_wb_ack}, 32'd0);
        check("reset_rdt", wb_if.o_wb_rdt, 32'd0);

        for (int v = 0; v < 16; v++) begin
            wb_access(vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].dat, rd, lat);
            check($sformatf("vec%0d_ack_latency", v), 32'(lat), 32'd1);
            if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
        end
        check("table_irq", {31'd0, irq}, 32'd0);

        // presc=3: one tick every 4 clocks
        wb_write(REG_MTIME, 32'd0, 4'hF);
        wb_write(REG_CTRL, 32'h0000_0301, 4'hF);
        repeat (40) @(posedge clk);
        #1;
        wb_read(REG_MTIME, rd);
        check("presc3_mtime", rd, 32'd10);

        // Compare match raises irq one cycle after MTIME reaches 5
        wb_write(REG_CTRL, 32'd0, 4'hF);
        wb_write(REG_MTIME, 32'd0, 4'hF);
        wb_write(REG_MTIMECMP, 32'd5, 4'hF);
        wb_write(REG_STATUS, 32'd1, 4'h1);
        wb_write(REG_CTRL, 32'h0000_0003, 4'hF);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check($sformatf("irq_rise_k%0d", k), {31'd0, irq}, (k >= 6) ? 32'd1 : 32'd0);
        end
        wb_if.i_wb_stb = 1'b1;
        wb_if.i_wb_we  = 1'b1;
        wb_if.i_wb_adr = REG_STATUS;
        wb_if.i_wb_sel = 4'h1;
        wb_if.i_wb_dat = 32'd1;
        @(posedge clk); #1;
        check("w1c_ack", {31'd0, wb_if.o_wb_ack}, 32'd1);
        check("w1c_irq_fall", {31'd0, irq}, 32'd0);
        wb_if.i_wb_stb = 1'b0;
        wb_if.i_wb_we  = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("irq_stays_low", {31'd0, irq}, 32'd0);

        // MTIME wrap without a matching compare
        wb_write(REG_CTRL, 32'd0, 4'hF);
        wb_write(REG_STATUS, 32'd1, 4'h1);
        wb_write(REG_MTIMECMP, 32'h8000_0000, 4'hF);
        wb_write(REG_MTIME, 32'hFFFF_FFFE, 4'hF);
        wb_write(REG_CTRL, 32'h0000_0001, 4'hF);
        wb_read(REG_MTIME, rd);
        check("wrap_pre", rd, 32'hFFFF_FFFF);
        wb_read(REG_MTIME, rd);
        check("wrap_post", rd, 32'd1);
        wb_read(REG_STATUS, rd);
        check("wrap_no_pending", rd, 32'd0);
        check("wrap_no_irq", {31'd0, irq}, 32'd0);

        // Set beats W1C; MTIMECMP writes leave pending alone
        wb_write(REG_CTRL, 32'd0, 4'hF);
        wb_write(REG_MTIME, 32'd100, 4'hF);
        wb_write(REG_MTIMECMP, 32'd100, 4'hF);
        wb_write(REG_STATUS, 32'd1, 4'h1);
        wb_write(REG_CTRL, 32'h0000_FF03, 4'hF);
        wb_write(REG_STATUS, 32'd1, 4'h1);
        check("set_wins_irq", {31'd0, irq}, 32'd1);
        wb_write(REG_MTIMECMP, 32'd200, 4'hF);
        wb_write(REG_MTIMECMP, 32'd300, 4'hF);
        @(posedge clk); #1;
        check("cmp_write_keeps_irq", {31'd0, irq}, 32'd1);
        wb_read(REG_STATUS, rd);
        check("status_pending", rd, 32'd1);
        wb_write(REG_STATUS, 32'd1, 4'h1);
        check("w1c_clears", {31'd0, irq}, 32'd0);
        wb_write(REG_MTIMECMP, 32'd100, 4'hF);
        @(posedge clk); #1;
        check("irq_before_rst", {31'd0, irq}, 32'd1);

        // Held strobe, then reset in the middle of it
        wb_if.i_wb_stb = 1'b1;
        wb_if.i_wb_we  = 1'b0;
        wb_if.i_wb_adr = REG_MTIME;
        check("hold_ack_0", {31'd0, wb_if.o_wb_ack}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack_%0d", i), {31'd0, wb_if.o_wb_ack}, 32'(i % 2));
        end
        rst = 1'b1;
        #1;
        check("rst_ack_drop", {31'd0, wb_if.o_wb_ack}, 32'd0);
        check("rst_irq_drop", {31'd0, irq}, 32'd0);
        check("rst_rdt_drop", wb_if.o_wb_rdt, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rel_no_ack", {31'd0, wb_if.o_wb_ack}, 32'd0);
        @(posedge clk); #1;
        check("rel_fresh_ack", {31'd0, wb_if.o_wb_ack}, 32'd1);
        check("rel_mtime", wb_if.o_wb_rdt, 32'd0);
        wb_if.i_wb_stb = 1'b0;
        wb_read(REG_MTIMECMP, rd);
        check("rst_mtimecmp", rd, 32'hFFFF_FFFF);
        wb_read(REG_CTRL, rd);
        check("rst_ctrl", rd, 32'd0);
        wb_read(REG_STATUS, rd);
        check("rst_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serving_timer.md
SERVING_TIMER -- requirements
Module: serving_timer

Interface
REQ-001 SHALL have parameter PRESC_RESET, default 8'd0, reset value of CTRL.presc (ticks every PRESC+1 clocks).
REQ-002 SHALL have parameter CMP_RESET, default 32'hFFFF_FFFF, reset value of MTIMECMP.
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_wb_adr  in  2  word address [3:2] within the 16-byte block.
REQ-006 i_wb_dat  in  32  write data.
REQ-007 i_wb_sel  in  4  byte enables for writes.
REQ-008 i_wb_we  in  1  1=write, 0=read.
REQ-009 i_wb_stb  in  1  request strobe (cycle=strobe), held high until ack.
REQ-010 o_wb_rdt  out  32  read data, valid only while o_wb_ack=1, else 0.
REQ-011 o_wb_ack  out  1  one-cycle acknowledge.
REQ-012 o_timer_irq  out  1  level interrupt to CPU i_timer_irq.

Function
REQ-013 Register map: 0x0 MTIME (R/W), 0x4 MTIMECMP (R/W), 0x8 CTRL (R/W: [0] en, [1] irq_en, [15:8] presc, other bits read 0), 0xC STATUS (R: [0] pending; W: bit0=1 clears pending).
REQ-014 Responder handshake: o_wb_ack registered = i_wb_stb & ~o_wb_ack; ack appears exactly one cycle after stb sampled high; a held stb yields ack every other cycle, never two consecutive ack cycles.
REQ-015 Writes commit on the ack cycle edge only (stb & we & ~ack), one access per ack; byte lanes with i_wb_sel=0 unchanged.
REQ-016 Read data registered together with ack from register state of the request cycle.
REQ-017 Prescaler: 8-bit counter; when en=1 increments each clock, on reaching presc wraps to 0 and issues one-cycle tick; when en=0 held at 0, no ticks.
REQ-018 MTIME increments by 1 on each tick; wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-019 Write to MTIME in same cycle as a tick: written value wins, tick dropped.
REQ-020 Write to CTRL.presc resets prescaler counter to 0.
REQ-021 pending set on any cycle with en=1 and MTIME == MTIMECMP (unsigned compare, current register values); sticky.
REQ-022 STATUS W1C with simultaneous set condition: set wins, pending stays 1.
REQ-023 o_timer_irq = pending & irq_en, combinational from registers, no extra latency.
REQ-024 Write to MTIMECMP does not itself clear pending.
REQ-025 Accesses are never stalled or errored; all four addresses always ack.

Reset
REQ-026 On i_rst high, asynchronously: MTIME=0, MTIMECMP=CMP_RESET, en=0, irq_en=0, presc=PRESC_RESET, prescaler=0, pending=0, o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0.
REQ-027 Reset asserted mid-transaction aborts it; no write commits; first ack after release requires a fresh stb sample.

Structure
REQ-028 Shared package holds register offsets (MTIME/MTIMECMP/CTRL/STATUS), CTRL bit positions, and prescaler width constant.
REQ-029 One sub-module natural: serving_timer_presc (prescaler counter, tick output); register file and handshake in top.

Verification
REQ-030 Reset, then read 0x4 -> ack one cycle after stb, rdt=32'hFFFF_FFFF; read 0x0 -> 0; o_timer_irq=0.
REQ-031 Write CTRL=32'h0000_0301 (presc=3, en=1) -> MTIME increments every 4 clocks; after 40 clocks MTIME=10 (+/-1 per handshake offset).
REQ-032 MTIMECMP=5, CTRL=32'h0000_0003 (presc=0, en, irq_en) -> o_timer_irq rises the cycle after MTIME reaches 5; write STATUS=1 while MTIME=7 -> irq falls next cycle.
REQ-033 MTIME=32'hFFFF_FFFE, presc=0, en=1 -> reads show wrap to 0 after two ticks; no irq unless MTIMECMP matches.
REQ-034 Write MTIME sel=4'b0010 dat=32'h0000_AB00 over MTIME=0 with en=0 -> MTIME=32'h0000_AB00; other bytes unchanged.
REQ-035 Held stb for 6 cycles -> ack pattern 0,1,0,1,0,1; assert i_rst during stb -> ack and irq drop immediately, registers at reset values.
